// File: rtl/serial_data_compare.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands CHUNK bits per clock, MSB first,
// stopping at the first differing chunk. Define SERIAL_CMP_SIGNED_EN for two's-complement operands.
module serial_data_compare #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic             oBusy,
  output logic             oValid,
  output logic [2:0]       oData
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           stateReg, stateNext;
  logic [WIDTH-1:0] saReg, saNext;
  logic [WIDTH-1:0] sbReg, sbNext;
  logic [2:0]       casReg, casNext;
  logic [2:0]       dataReg, dataNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  logic [WIDTH-1:0] aIn, bIn;
  logic [CHUNK-1:0] topA, topB;
  logic             casOneHot;

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  assign aIn = iData_a ^ MSB_MASK;
  assign bIn = iData_b ^ MSB_MASK;
`else
  assign aIn = iData_a;
  assign bIn = iData_b;
`endif

  assign topA      = saReg[WIDTH-1 -: CHUNK];
  assign topB      = sbReg[WIDTH-1 -: CHUNK];
  assign casOneHot = (casReg == 3'b100) || (casReg == 3'b010) || (casReg == 3'b001);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg <= IDLE;
      saReg    <= '0;
      sbReg    <= '0;
      casReg   <= '0;
      dataReg  <= '0;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      saReg    <= saNext;
      sbReg    <= sbNext;
      casReg   <= casNext;
      dataReg  <= dataNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    saNext    = saReg;
    sbNext    = sbReg;
    casNext   = casReg;
    dataNext  = dataReg;
    cntNext   = cntReg;
    unique case (stateReg)
      IDLE: begin
        if (iStart) begin
          saNext    = aIn;
          sbNext    = bIn;
          casNext   = iData;
          cntNext   = CNT_W'(NCHUNK);
          stateNext = RUN;
        end
      end
      RUN: begin
        if (topA > topB) begin
          dataNext  = 3'b100;
          stateNext = DONE;
        end else if (topA < topB) begin
          dataNext  = 3'b001;
          stateNext = DONE;
        end else if (cntReg > CNT_W'(1)) begin
          saNext  = saReg << CHUNK;
          sbNext  = sbReg << CHUNK;
          cntNext = cntReg - CNT_W'(1);
        end else begin
          // Fully equal: defer to the cascade input, but only trust it when one-hot.
          dataNext  = casOneHot ? casReg : 3'b010;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign oBusy  = (stateReg != IDLE);
  assign oValid = (stateReg == DONE);
  assign oData  = dataReg;

endmodule

// File: tb/tb_serial_data_compare.sv
// Scoreboard bench for serial_data_compare (WIDTH=16, CHUNK=4): directed vectors push expected
// result and arrival cycle; a negedge monitor pops and compares on every oValid pulse.
module tb_serial_data_compare;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [15:0] iData_a, iData_b;
  logic [2:0]  iData;
  logic        oBusy, oValid;
  logic [2:0]  oData;

  typedef struct {
    logic [2:0] data;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   nVec = 0;
  int   nErr = 0;
  logic [2:0] lastExp = 3'b000;

  serial_data_compare #(.WIDTH(16), .CHUNK(4)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iData_a(iData_a), .iData_b(iData_b), .iData(iData),
    .oBusy(oBusy), .oValid(oValid), .oData(oData)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every oValid pulse must match the oldest pending expectation, in data and in cycle.
  always @(negedge iClk) begin
    if (oValid) begin
      if (expQ.size() == 0) begin
        check("spurious_oValid", 32'(oValid), 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("oData", 32'(oData), 32'(e.data));
        check("valid_cycle", cyc, e.cyc);
        $display("result oData=%03b at cycle %0d (expected %03b at %0d)", oData, cyc, e.data, e.cyc);
      end
    end
  end

  // Issue one compare; decision expected at RUN edge j. With stream=1 iStart stays high with
  // fresh junk operands during the busy cycles, which must all be ignored.
  task automatic doCmp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] cas,
                       input logic [2:0] ed, input int j, input bit stream);
    exp_t e;
    @(negedge iClk);
    iStart  = 1'b1;
    iData_a = a;
    iData_b = b;
    iData   = cas;
    e.data  = ed;
    e.cyc   = cyc + 1 + j;
    expQ.push_back(e);
    lastExp = ed;
    $display("issue A=%04h B=%04h cas=%03b expect %03b after RUN edge %0d", a, b, cas, ed, j);
    for (int k = 0; k <= j; k++) begin
      @(negedge iClk);
      if (k == 0) check("busy_after_accept", 32'(oBusy), 32'd1);
      iStart  = stream;
      iData_a = 16'($urandom);
      iData_b = 16'($urandom);
      iData   = 3'($urandom);
    end
  endtask

  initial begin
    logic [2:0] exp2;
`ifdef SERIAL_CMP_SIGNED_EN
    exp2 = 3'b001;
`else
    exp2 = 3'b100;
`endif
    iRst = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0; iData = '0;
    repeat (2) @(negedge iClk);
    check("reset_oBusy", 32'(oBusy), 32'd0);
    check("reset_oValid", 32'(oValid), 32'd0);
    check("reset_oData", 32'(oData), 32'd0);
    iRst = 1'b0;

    doCmp(16'h1234, 16'h1234, 3'b001, 3'b001, 4, 1'b0);
    doCmp(16'h8000, 16'h0001, 3'b010, exp2,   1, 1'b0);
    doCmp(16'h12A4, 16'h12B4, 3'b010, 3'b001, 3, 1'b0);
    doCmp(16'hFFFF, 16'hFFFF, 3'b011, 3'b010, 4, 1'b0);
    doCmp(16'h5678, 16'h5679, 3'b100, 3'b001, 4, 1'b0);
    doCmp(16'h0F00, 16'h0E00, 3'b001, 3'b100, 2, 1'b0);
    doCmp(16'h0000, 16'h0000, 3'b000, 3'b010, 4, 1'b0);

    // iStart held high, operands changing every cycle
    doCmp(16'hA1B2, 16'hA1B2, 3'b010, 3'b010, 4, 1'b1);
    doCmp(16'h7000, 16'h6FFF, 3'b001, 3'b100, 1, 1'b1);
    doCmp(16'h3C3C, 16'h3C4C, 3'b100, 3'b001, 3, 1'b1);
    doCmp(16'hFFFF, 16'hFFFF, 3'b100, 3'b100, 4, 1'b0);

    // Reset at the second RUN edge aborts the compare
    @(negedge iClk);
    iStart = 1'b1; iData_a = 16'h1234; iData_b = 16'h1234; iData = 3'b001;
    @(negedge iClk);
    iStart = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    check("abort_oBusy", 32'(oBusy), 32'd0);
    check("abort_oValid", 32'(oValid), 32'd0);
    check("abort_oData", 32'(oData), 32'd0);
    repeat (6) @(negedge iClk);
    check("abort_idle", 32'(oBusy), 32'd0);

    doCmp(16'h4321, 16'h4312, 3'b001, 3'b100, 3, 1'b0);

    for (int t = 0; t < 100 && expQ.size() != 0; t++) @(negedge iClk);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge iClk);
    check("oData_held", 32'(oData), 32'(lastExp));
    check("final_oValid", 32'(oValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/serial_data_compare.md
Name: serial_data_compare

Overview:
Parametrised, multi-cycle magnitude comparator. It is the sequential successor to the team's 4-bit cascadable comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first.
- Terminates early on the first differing chunk.
- Falls back to a cascade input when the operands are fully equal.
- Sits between operand registers and control logic that needs wide compares without a wide combinational path.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits compared per RUN cycle; 1 <= CHUNK <= WIDTH.

Ports:
iClk  input  1  clock; all state changes on rising edge.
iRst  input  1  synchronous reset, active-high.
iStart  input  1  request a compare; accepted only when oBusy=0.
iData_a  input  WIDTH  operand A; sampled on the accepting edge.
iData_b  input  WIDTH  operand B; sampled on the accepting edge.
iData  input  3  cascade input, one-hot {gt,eq,lt}; sampled on the accepting edge.
oBusy  output  1  high in RUN and DONE.
oValid  output  1  one-cycle pulse; oData is fresh.
oData  output  3  result, one-hot: bit2 A>B, bit1 A==B, bit0 A<B; held until the next result.

Behaviour:
- Interface: one clock (iClk); reset iRst is synchronous and active-high.
- Reset values: state=IDLE, oBusy=0, oValid=0, oData=3'b000, internal shift registers and counter = 0.
- Reset asserted mid-operation aborts the compare: no oValid and no oData update; the block is in IDLE on the cycle after the edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - Edge with iStart=1 latches iData_a, iData_b and iData into sa, sb and cas.
  - Loads chunk counter = WIDTH/CHUNK and moves to RUN.
  - With iStart=0, stays in IDLE.
- RUN, each edge compares the top CHUNK bits of sa and sb as unsigned values:
  - Top of sa > top of sb: oData <= 100, go to DONE.
  - Top of sa < top of sb: oData <= 001, go to DONE.
  - Chunks equal, counter > 1: shift sa and sb left by CHUNK, decrement counter, stay in RUN.
  - Chunks equal, counter == 1 (last chunk): oData <= cas if cas is one-hot, else 010; go to DONE.
- DONE: oValid=1 for exactly this cycle; the next edge returns to IDLE with oValid=0 and oBusy=0.
- Latency from the accepting edge E0:
  - A decision at RUN edge Ej (1 <= j <= WIDTH/CHUNK) gives oValid high in the cycle after Ej.
  - Worst case is WIDTH/CHUNK+1 cycles; minimum is 2.
- iStart while oBusy=1 is ignored, with no queuing. Back-to-back compares require one IDLE edge between them.
- The latched operands are immune to input changes after E0.
- CHUNK == WIDTH gives a single-RUN-cycle compare; the latency is always 2.

Optional Feature:
Macro SERIAL_CMP_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - The MSB of sa and sb is inverted when latched, mapping signed order onto unsigned.
  - The result encoding is unchanged.
- Undefined: pure unsigned compare.

Test Plan:
1. WIDTH=16, CHUNK=4: A=0x1234, B=0x1234, iData=001 -> four RUN cycles; oValid in cycle 5 after E0; oData=001.
2. A=0x8000, B=0x0001, unsigned -> decided at the first RUN edge; oValid in cycle 2; oData=100. With SERIAL_CMP_SIGNED_EN -> oData=001.
3. A=0x12A4, B=0x12B4 -> decided at the third RUN edge; oData=001; oValid in cycle 4.
4. Equal operands (0xFFFF, 0xFFFF) with iData=011 (not one-hot) -> oData=010.
5. iStart held high continuously with operands changing every cycle -> each compare uses values from its own accepting edge; one idle edge between oValid pulses. iStart during busy is ignored.
6. iRst pulsed at the second RUN edge of a compare -> no oValid; oBusy=0 and oData=000 next cycle; a fresh iStart then completes normally.
